// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with write-back bypass, load-use bubble insertion and bubble counter
module id_ex_stage #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 5
) (
    input  logic              r_clk,
    input  logic              r_rst,
    input  logic              id_valid,
    input  logic [AWIDTH-1:0] id_rs_addr,
    input  logic [AWIDTH-1:0] id_rt_addr,
    input  logic [AWIDTH-1:0] id_rd_addr,
    input  logic [DWIDTH-1:0] id_rs_data,
    input  logic [DWIDTH-1:0] id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic              id_reg_wr,
    input  logic              id_mem_rd,
    input  logic              id_mem_wr,
    input  logic              id_alu_src,
    input  logic [3:0]        id_alu_op,
    input  logic              wb_wr_en,
    input  logic [AWIDTH-1:0] wb_addr,
    input  logic [DWIDTH-1:0] wb_data,
    input  logic              stall,
    input  logic              flush,
    output logic              stall_req,
    output logic              ex_valid,
    output logic [DWIDTH-1:0] ex_rs_data,
    output logic [DWIDTH-1:0] ex_rt_data,
    output logic [AWIDTH-1:0] ex_rs_addr,
    output logic [AWIDTH-1:0] ex_rt_addr,
    output logic [AWIDTH-1:0] ex_rd_addr,
    output logic [DWIDTH-1:0] ex_imm,
    output logic              ex_reg_wr,
    output logic              ex_mem_rd,
    output logic              ex_mem_wr,
    output logic              ex_alu_src,
    output logic [3:0]        ex_alu_op,
    output logic [15:0]       bubble_cnt
);
    logic              hz;
    logic [DWIDTH-1:0] rs_eff;
    logic [DWIDTH-1:0] rt_eff;
    logic [DWIDTH-1:0] imm_ext;

    // Same-cycle write-back bypass (register 0 included), immediate sign extension and load-use detection
    always_comb begin
        rs_eff    = (wb_wr_en && wb_addr == id_rs_addr) ? wb_data : id_rs_data;
        rt_eff    = (wb_wr_en && wb_addr == id_rt_addr) ? wb_data : id_rt_data;
        imm_ext   = {{(DWIDTH-16){id_imm[15]}}, id_imm};
        hz        = id_valid & ex_valid & ex_mem_rd & ex_reg_wr &
                    (ex_rd_addr == id_rs_addr | ex_rd_addr == id_rt_addr);
        stall_req = hz & ~flush;
    end

    // Pipeline register: flush kills, stall holds, hazard inserts a counted bubble, otherwise load
    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            ex_valid   <= 1'b0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_rs_addr <= '0;
            ex_rt_addr <= '0;
            ex_rd_addr <= '0;
            ex_imm     <= '0;
            ex_reg_wr  <= 1'b0;
            ex_mem_rd  <= 1'b0;
            ex_mem_wr  <= 1'b0;
            ex_alu_src <= 1'b0;
            ex_alu_op  <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            ex_valid  <= 1'b0;
            ex_reg_wr <= 1'b0;
            ex_mem_rd <= 1'b0;
            ex_mem_wr <= 1'b0;
        end else if (!stall) begin
            if (hz) begin
                ex_valid   <= 1'b0;
                ex_reg_wr  <= 1'b0;
                ex_mem_rd  <= 1'b0;
                ex_mem_wr  <= 1'b0;
                ex_alu_src <= 1'b0;
                if (bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
            end else begin
                ex_valid   <= id_valid;
                ex_rs_data <= rs_eff;
                ex_rt_data <= rt_eff;
                ex_rs_addr <= id_rs_addr;
                ex_rt_addr <= id_rt_addr;
                ex_rd_addr <= id_rd_addr;
                ex_imm     <= imm_ext;
                ex_reg_wr  <= id_reg_wr & id_valid;
                ex_mem_rd  <= id_mem_rd & id_valid;
                ex_mem_wr  <= id_mem_wr & id_valid;
                ex_alu_src <= id_alu_src;
                ex_alu_op  <= id_alu_op;
            end
        end
    end
endmodule
